dsm_dac_ctrl: RTL and testbench

Sample-feed controller for the delta-sigma DAC path. It accepts signed PCM samples from an upstream source (sine generator, host, DMA) over a valid/ready interface and buffers them in a small FIFO. It paces them into the modulator's `dsm_in` at one sample every `OSR` clocks, and sequences modulator reset and enable through start, run, underrun and drain. It sits between the sample source and the first- or second-order DSM DAC, replacing the free-running `clk_div` pacing.

---
 rtl/dsm_ctrl_pkg.sv | 22 ++
 rtl/dsm_sample_fifo.sv | 56 +++++
 rtl/dsm_dac_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_dsm_dac_ctrl.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/dsm_ctrl_pkg.sv
// Shared types and helpers for the delta-sigma DAC sample-feed controller.
package dsm_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2,
        DRAIN = 2'd3
    } dsm_ctrl_state_t;

    localparam int UNDERRUN_CNT_W = 16;

    // Saturating increment for the underrun counter: sticks at all-ones.
    function automatic logic [UNDERRUN_CNT_W-1:0] sat_inc(input logic [UNDERRUN_CNT_W-1:0] v);
        if (v == {UNDERRUN_CNT_W{1'b1}}) begin
            return v;
        end else begin
            return v + {{(UNDERRUN_CNT_W-1){1'b0}}, 1'b1};
        end
    endfunction

endpackage

// File: rtl/dsm_sample_fifo.sv
// Synchronous sample FIFO: wrap-bit pointers, show-ahead read data,
// no bypass from write to read while empty, synchronous flush on rst.
module dsm_sample_fifo #(
    parameter int DATA_WIDTH = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          push,
    input  logic [DATA_WIDTH-1:0]         wr_data,
    input  logic                          pop,
    output logic [DATA_WIDTH-1:0]         rd_data,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   level
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic [DATA_WIDTH-1:0] mem_r [FIFO_DEPTH];
    logic [AW:0]           wr_ptr_r;
    logic [AW:0]           rd_ptr_r;
    logic                  full_s;
    logic                  do_push_s;
    logic                  do_pop_s;

    assign empty     = (wr_ptr_r == rd_ptr_r);
    assign full_s    = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                       (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign level     = wr_ptr_r - rd_ptr_r;
    assign do_push_s = push && !full_s;
    assign do_pop_s  = pop && !empty;
    assign rd_data   = mem_r[rd_ptr_r[AW-1:0]];

    // Pointer update; rst flushes by collapsing both pointers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + {{AW{1'b0}}, 1'b1};
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + {{AW{1'b0}}, 1'b1};
            end
        end
    end

    // Sample storage; contents are don't-care once the pointers are flushed.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= wr_data;
        end
    end

endmodule

// File: rtl/dsm_dac_ctrl.sv
// Sample-feed controller for the DSM DAC: buffers PCM samples, paces one
// sample into the modulator every OSR clocks, and sequences modulator
// reset/enable through IDLE, PRIME, RUN and DRAIN.
module dsm_dac_ctrl
    import dsm_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH    = 16,
    parameter int OSR           = 100,
    parameter int FIFO_DEPTH    = 8,
    parameter int UNDERRUN_HOLD = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enable,
    input  logic [DATA_WIDTH-1:0]         s_data,
    input  logic                          s_valid,
    output logic                          s_ready,
    output logic [DATA_WIDTH-1:0]         dsm_in,
    output logic                          dsm_clk_en,
    output logic                          dsm_rst,
    output logic                          sample_strobe,
    output logic                          underrun,
    output logic [UNDERRUN_CNT_W-1:0]     underrun_cnt,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [1:0]                    state
);

    localparam int              LVL_W       = $clog2(FIFO_DEPTH) + 1;
    localparam logic [15:0]     PCNT_LAST   = 16'(OSR - 1);
    localparam logic [LVL_W-1:0] PRIME_LEVEL = LVL_W'(FIFO_DEPTH / 2);
    localparam logic [LVL_W-1:0] FULL_LEVEL  = LVL_W'(FIFO_DEPTH);

    dsm_ctrl_state_t             state_r;
    dsm_ctrl_state_t             state_next_s;
    logic [15:0]                 pcnt_r;
    logic [DATA_WIDTH-1:0]       dsm_in_r;
    logic [DATA_WIDTH-1:0]       last_r;
    logic [UNDERRUN_CNT_W-1:0]   ucnt_r;
    logic                        dsm_rst_r;
    logic                        dsm_clk_en_r;
    logic                        drained_r;

    logic [DATA_WIDTH-1:0]       fifo_rd_data_s;
    logic                        fifo_empty_s;
    logic [LVL_W-1:0]            level_s;
    logic                        active_s;
    logic                        strobe_s;
    logic                        starve_s;
    logic                        underrun_s;
    logic                        push_s;
    logic                        pop_s;

    // The period counter only runs while the modulator is being fed.
    assign active_s   = (state_r == RUN) || (state_r == DRAIN);
    assign strobe_s   = active_s && (pcnt_r == 16'd0);
    // A strobe that finds the FIFO empty: an underrun in RUN, end-of-data in DRAIN.
    assign starve_s   = strobe_s && fifo_empty_s;
    assign underrun_s = starve_s && (state_r == RUN);
    assign pop_s      = strobe_s && !fifo_empty_s;
    assign s_ready    = (level_s != FULL_LEVEL) && (state_r != DRAIN);
    assign push_s     = s_valid && s_ready;

    dsm_sample_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push_s),
        .wr_data (s_data),
        .pop     (pop_s),
        .rd_data (fifo_rd_data_s),
        .empty   (fifo_empty_s),
        .level   (level_s)
    );

    // Next-state decode; dropping enable always wins over the prime threshold.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (enable) begin
                    state_next_s = PRIME;
                end else begin
                    state_next_s = IDLE;
                end
            end
            PRIME: begin
                if (!enable) begin
                    state_next_s = IDLE;
                end else if (level_s >= PRIME_LEVEL) begin
                    state_next_s = RUN;
                end else begin
                    state_next_s = PRIME;
                end
            end
            RUN: begin
                if (!enable) begin
                    state_next_s = DRAIN;
                end else begin
                    state_next_s = RUN;
                end
            end
            DRAIN: begin
                if (enable) begin
                    state_next_s = RUN;
                end else if (drained_r && (pcnt_r == PCNT_LAST)) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = DRAIN;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // State register with modulator controls registered from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            dsm_rst_r    <= 1'b1;
            dsm_clk_en_r <= 1'b0;
        end else begin
            state_r      <= state_next_s;
            dsm_rst_r    <= (state_next_s == IDLE);
            dsm_clk_en_r <= (state_next_s == RUN) || (state_next_s == DRAIN);
        end
    end

    // Sample-period counter: wraps at OSR-1, held at zero outside RUN/DRAIN.
    always_ff @(posedge clk) begin
        if (rst) begin
            pcnt_r <= 16'd0;
        end else if (active_s) begin
            if (pcnt_r == PCNT_LAST) begin
                pcnt_r <= 16'd0;
            end else begin
                pcnt_r <= pcnt_r + 16'd1;
            end
        end else begin
            pcnt_r <= 16'd0;
        end
    end

    // Marks that DRAIN has output its zero period; cleared on leaving DRAIN.
    always_ff @(posedge clk) begin
        if (rst) begin
            drained_r <= 1'b0;
        end else if (state_next_s != DRAIN) begin
            drained_r <= 1'b0;
        end else if (starve_s && (state_r == DRAIN)) begin
            drained_r <= 1'b1;
        end
    end

    // Modulator sample and last-popped sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            dsm_in_r <= '0;
            last_r   <= '0;
        end else if (!active_s) begin
            dsm_in_r <= '0;
        end else if (pop_s) begin
            dsm_in_r <= fifo_rd_data_s;
            last_r   <= fifo_rd_data_s;
        end else if (underrun_s) begin
            dsm_in_r <= (UNDERRUN_HOLD != 0) ? last_r : '0;
        end else if (starve_s) begin
            dsm_in_r <= '0;
        end
    end

    // Underrun counter, saturating, cleared only by rst.
    always_ff @(posedge clk) begin
        if (rst) begin
            ucnt_r <= '0;
        end else if (underrun_s) begin
            ucnt_r <= sat_inc(ucnt_r);
        end
    end

    assign dsm_in        = dsm_in_r;
    assign dsm_rst       = dsm_rst_r;
    assign dsm_clk_en    = dsm_clk_en_r;
    assign sample_strobe = strobe_s;
    assign underrun      = underrun_s;
    assign underrun_cnt  = ucnt_r;
    assign fifo_level    = level_s;
    assign state         = state_r;

endmodule

// File: tb/tb_dsm_dac_ctrl.sv
// Bench for dsm_dac_ctrl: two instances (hold / zero on underrun) share
// stimulus; a queue-based model predicts every output each cycle, and
// directed scenarios pin the model with hand-computed values.
module tb_dsm_dac_ctrl;

    localparam int OSR   = 4;
    localparam int DEPTH = 8;
    localparam int S_IDLE = 0, S_PRIME = 1, S_RUN = 2, S_DRAIN = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic [15:0] s_data = 16'd0;
    logic        s_valid = 1'b0;

    logic        s_ready_h, s_ready_z;
    logic [15:0] dsm_h, dsm_z;
    logic        clk_en_h, clk_en_z, drst_h, drst_z, stb_h, stb_z, ur_h, ur_z;
    logic [15:0] ucnt_h, ucnt_z;
    logic [3:0]  lvl_h, lvl_z;
    logic [1:0]  state_h, state_z;

    always #5 clk = ~clk;

    dsm_dac_ctrl #(.DATA_WIDTH(16), .OSR(OSR), .FIFO_DEPTH(DEPTH), .UNDERRUN_HOLD(1)) dut_h (
        .clk(clk), .rst(rst), .enable(enable), .s_data(s_data), .s_valid(s_valid),
        .s_ready(s_ready_h), .dsm_in(dsm_h), .dsm_clk_en(clk_en_h), .dsm_rst(drst_h),
        .sample_strobe(stb_h), .underrun(ur_h), .underrun_cnt(ucnt_h),
        .fifo_level(lvl_h), .state(state_h));

    dsm_dac_ctrl #(.DATA_WIDTH(16), .OSR(OSR), .FIFO_DEPTH(DEPTH), .UNDERRUN_HOLD(0)) dut_z (
        .clk(clk), .rst(rst), .enable(enable), .s_data(s_data), .s_valid(s_valid),
        .s_ready(s_ready_z), .dsm_in(dsm_z), .dsm_clk_en(clk_en_z), .dsm_rst(drst_z),
        .sample_strobe(stb_z), .underrun(ur_z), .underrun_cnt(ucnt_z),
        .fifo_level(lvl_z), .state(state_z));

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    // behavioural model
    logic [15:0] q[$];
    int          m_mode = S_IDLE;
    int          m_phase = 0;
    logic [15:0] m_dsm_h = 16'd0, m_dsm_z = 16'd0, m_last = 16'd0;
    int          m_ucnt = 0;
    bit          m_zero_period = 1'b0;

    // scenario bookkeeping
    logic [15:0] exp_play[4];
    logic [15:0] seen[$];
    logic [15:0] prev;
    int          n_steps, n_ur, acc;
    bit          en_r;
    int          vprob;

    function automatic bit m_active();
        return (m_mode == S_RUN) || (m_mode == S_DRAIN);
    endfunction

    function automatic bit m_strobe();
        return m_active() && (m_phase == 0);
    endfunction

    function automatic bit m_ready();
        return (q.size() != DEPTH) && (m_mode != S_DRAIN);
    endfunction

    function automatic bit m_underrun();
        return (m_mode == S_RUN) && m_strobe() && (q.size() == 0);
    endfunction

    task automatic model_step();
        int  lvl;
        bit  stb;
        bit  push;
        int  nxt;
        if (rst) begin
            q.delete();
            m_mode = S_IDLE; m_phase = 0;
            m_dsm_h = 16'd0; m_dsm_z = 16'd0; m_last = 16'd0;
            m_ucnt = 0; m_zero_period = 1'b0;
            return;
        end
        lvl  = q.size();
        stb  = m_strobe();
        push = s_valid && m_ready();
        if (!m_active()) begin
            m_dsm_h = 16'd0; m_dsm_z = 16'd0;
        end else if (stb && lvl > 0) begin
            m_last = q.pop_front();
            m_dsm_h = m_last; m_dsm_z = m_last;
        end else if (stb && m_mode == S_RUN) begin
            if (m_ucnt < 65535) m_ucnt++;
            m_dsm_h = m_last; m_dsm_z = 16'd0;
        end else if (stb) begin
            m_dsm_h = 16'd0; m_dsm_z = 16'd0;
        end
        if (push) q.push_back(s_data);
        nxt = m_mode;
        case (m_mode)
            S_IDLE:  if (enable) nxt = S_PRIME;
            S_PRIME: if (!enable) nxt = S_IDLE; else if (lvl >= DEPTH / 2) nxt = S_RUN;
            S_RUN:   if (!enable) nxt = S_DRAIN;
            S_DRAIN: if (enable) nxt = S_RUN;
                     else if (m_zero_period && m_phase == OSR - 1) nxt = S_IDLE;
            default: nxt = S_IDLE;
        endcase
        if (nxt != S_DRAIN) m_zero_period = 1'b0;
        else if (m_mode == S_DRAIN && stb && lvl == 0) m_zero_period = 1'b1;
        m_phase = m_active() ? (m_phase + 1) % OSR : 0;
        m_mode  = nxt;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: dut=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        chk("state_h", state_h, m_mode);          chk("state_z", state_z, m_mode);
        chk("dsm_rst_h", drst_h, m_mode == S_IDLE);
        chk("dsm_rst_z", drst_z, m_mode == S_IDLE);
        chk("clk_en_h", clk_en_h, m_active());    chk("clk_en_z", clk_en_z, m_active());
        chk("s_ready_h", s_ready_h, m_ready());   chk("s_ready_z", s_ready_z, m_ready());
        chk("strobe_h", stb_h, m_strobe());       chk("strobe_z", stb_z, m_strobe());
        chk("underrun_h", ur_h, m_underrun());    chk("underrun_z", ur_z, m_underrun());
        chk("ucnt_h", ucnt_h, m_ucnt);            chk("ucnt_z", ucnt_z, m_ucnt);
        chk("level_h", lvl_h, q.size());          chk("level_z", lvl_z, q.size());
        chk("dsm_in_h", dsm_h, m_dsm_h);          chk("dsm_in_z", dsm_z, m_dsm_z);
    endtask

    // One clock: drive inputs, advance model at the edge, compare at negedge.
    task automatic step(input bit r, input bit en, input bit v, input logic [15:0] d);
        rst = r; enable = en; s_valid = v; s_data = d;
        @(posedge clk);
        model_step();
        if (r) chk_en = 1'b1;
        @(negedge clk);
        if (chk_en) compare_all();
    endtask

    initial begin
        exp_play[0] = 16'hFFFB; exp_play[1] = 16'hFFFA;
        exp_play[2] = 16'hFFF9; exp_play[3] = 16'h0000;

        // reset
        repeat (3) step(1'b1, 1'b0, 1'b0, 16'd0);
        chk("rst_state", state_h, 2'd0);   chk("rst_dsm_rst", drst_h, 1'b1);
        chk("rst_clk_en", clk_en_h, 1'b0); chk("rst_dsm_in", dsm_h, 16'd0);
        chk("rst_s_ready", s_ready_h, 1'b1); chk("rst_ucnt", ucnt_h, 16'd0);
        chk("rst_level", lvl_h, 4'd0);

        // prime and pacing
        step(1'b0, 1'b1, 1'b1, 16'd100); step(1'b0, 1'b1, 1'b1, 16'd200);
        step(1'b0, 1'b1, 1'b1, 16'd300); step(1'b0, 1'b1, 1'b1, 16'd400);
        chk("prime_level", lvl_h, 4'd4); chk("prime_state", state_h, 2'd1);
        step(1'b0, 1'b1, 1'b0, 16'd0);
        chk("run_entry", state_h, 2'd2); chk("first_strobe", stb_h, 1'b1);
        for (int k = 0; k < 4; k++) begin
            step(1'b0, 1'b1, 1'b0, 16'd0);
            chk("pace_dsm_in", dsm_h, 16'd100 * 16'(k + 1));
            repeat (3) step(1'b0, 1'b1, 1'b0, 16'd0);
            chk("pace_strobe", stb_h, 1'b1);
        end

        // underrun (5th strobe), with a coincident push that must not bypass
        chk("underrun_pulse", ur_h, 1'b1);
        step(1'b0, 1'b1, 1'b1, 16'hFFFB);
        chk("hold_dsm_in", dsm_h, 16'd400); chk("zero_dsm_in", dsm_z, 16'd0);
        chk("ucnt_one", ucnt_h, 16'd1);     chk("no_bypass_level", lvl_h, 4'd1);
        step(1'b0, 1'b1, 1'b1, 16'hFFFA);
        step(1'b0, 1'b1, 1'b1, 16'hFFF9);

        // drain
        prev = dsm_h; n_steps = 0; n_ur = 0;
        do begin
            step(1'b0, 1'b0, 1'b0, 16'd0);
            n_steps++;
            if (ur_h) n_ur++;
            if (dsm_h !== prev) begin seen.push_back(dsm_h); prev = dsm_h; end
        end while (state_h != 2'd0 && n_steps < 40);
        chk("drain_steps", n_steps, 17);
        chk("drain_underruns", n_ur, 0);
        chk("drain_seq_len", seen.size(), 4);
        for (int i = 0; i < seen.size() && i < 4; i++) chk("drain_seq", seen[i], exp_play[i]);
        chk("drain_idle_rst", drst_h, 1'b1);

        // backpressure in IDLE
        acc = 0;
        for (int i = 1; i <= 10; i++) begin
            if (s_ready_h) acc++;
            step(1'b0, 1'b0, 1'b1, 16'(i));
        end
        chk("bp_accepted", acc, 8); chk("bp_level", lvl_h, 4'd8);
        chk("bp_s_ready", s_ready_h, 1'b0); chk("bp_state", state_h, 2'd0);

        // prefilled IDLE -> RUN in two edges
        step(1'b0, 1'b1, 1'b0, 16'd0);
        step(1'b0, 1'b1, 1'b0, 16'd0);
        chk("fast_run", state_h, 2'd2); chk("fast_strobe", stb_h, 1'b1);
        step(1'b0, 1'b1, 1'b0, 16'd0);
        chk("fast_dsm_in", dsm_h, 16'd1); chk("fast_level", lvl_h, 4'd7);
        chk("ucnt_kept", ucnt_h, 16'd1);

        // mid-run reset
        step(1'b1, 1'b1, 1'b0, 16'd0);
        chk("mrst_level", lvl_h, 4'd0); chk("mrst_ucnt", ucnt_h, 16'd0);
        chk("mrst_dsm_in", dsm_h, 16'd0); chk("mrst_state", state_h, 2'd0);
        chk("mrst_dsm_rst", drst_h, 1'b1);

        // randomized traffic
        en_r = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            case ((i / 500) % 4)
                0: vprob = 20;
                1: vprob = 50;
                2: vprob = 90;
                default: vprob = 10;
            endcase
            if ($urandom_range(0, 29) == 0) en_r = !en_r;
            step(($urandom_range(0, 599) == 0), en_r,
                 ($urandom_range(0, 99) < vprob), 16'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
